tl_ul_responder: RTL
====================

TL_UL_RESPONDER -- requirements
Module: tl_ul_responder

Interface
REQ-001 The block SHALL have parameter AW, default 12, meaning the byte-address width of the A channel.
REQ-002 The block SHALL have parameter DW, default 32, meaning the data width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_valid_i  input  1  A-channel request valid.
REQ-006 a_ready_o  output  1  A-channel request accepted when high with a_valid_i.
REQ-007 a_opcode_i  input  3  0=PutFullData, 1=PutPartialData, 4=Get.
REQ-008 a_size_i  input  2  log2 bytes: 0=1B, 1=2B, 2=4B.
REQ-009 a_address_i  input  AW  byte address.
REQ-010 a_mask_i  input  4  byte lane enables.
REQ-011 a_data_i  input  32  write data.
REQ-012 d_valid_o  output  1  D-channel response valid.
REQ-013 d_ready_i  input  1  D-channel response accepted.
REQ-014 d_opcode_o  output  3  0=AccessAck, 1=AccessAckData.
REQ-015 d_size_o  output  2  echo of accepted a_size_i.
REQ-016 d_data_o  output  32  read data; 0 for AccessAck.
REQ-017 d_error_o  output  1  request was rejected.
REQ-018 mem_req_o  output  1  one-cycle memory strobe.
REQ-019 mem_we_o  output  1  write enable, qualified by mem_req_o.
REQ-020 mem_addr_o  output  AW-2  word address (a_address_i[AW-1:2]).
REQ-021 mem_be_o  output  4  byte enables.
REQ-022 mem_wdata_o  output  32  write data.
REQ-023 mem_rdata_i  input  32  read data, valid the cycle after mem_req_o.

Function
REQ-024 The FSM SHALL have states IDLE, ACCESS, WAIT_RD, RESP; a_ready_o SHALL be 1 only in IDLE (one outstanding request).
REQ-025 On handshake in cycle N, opcode, size, address, mask and data SHALL be registered and the FSM SHALL leave IDLE.
REQ-026 A request SHALL be illegal if opcode not in {0,1,4}, size=3, address misaligned for its size, or mask zero or with lanes outside the addressed size/offset.
REQ-027 PutFullData SHALL also be illegal unless the mask exactly covers the addressed bytes.
REQ-028 Legal Put: ACCESS in N+1 with mem_req_o=1, mem_we_o=1, mem_be_o=mask, then RESP with d_valid_o from N+2, AccessAck, d_error_o=0.
REQ-029 Legal Get: ACCESS in N+1 with mem_req_o=1, mem_we_o=0, mem_be_o=mask; WAIT_RD in N+2 captures mem_rdata_i; RESP from N+3 with AccessAckData and the full captured word.
REQ-030 Illegal request: no memory strobe; RESP from N+1 with d_error_o=1, d_opcode_o per original opcode class (Get->1, else 0), d_data_o=0.
REQ-031 In RESP, all d_* outputs SHALL be registered and held stable while d_valid_o=1 and d_ready_i=0.
REQ-032 On d_valid_o & d_ready_i, the FSM SHALL return to IDLE; a_ready_o SHALL be 1 the next cycle (no same-cycle turnaround).
REQ-033 mem_req_o SHALL be high for exactly one cycle per legal request; other mem_* outputs are don't-care when mem_req_o=0 but SHALL be driven from registers.
REQ-034 a_valid_i outside IDLE SHALL be ignored.

Reset
REQ-035 Reset SHALL force state IDLE and a_ready_o=0 during reset, 1 in the first cycle after release.
REQ-036 Reset SHALL clear d_valid_o, d_error_o, mem_req_o, mem_we_o, all data/address/mask registers to 0.
REQ-037 Reset mid-transaction SHALL abort it; no response SHALL be issued for it.

Structure
REQ-038 A shared package tl_pkg SHALL hold the A/D opcode enums, size encodings and the FSM state typedef.
REQ-039 Legality checking SHALL be a combinational sub-module tl_req_check (opcode, size, address, mask -> legal).

Verification
REQ-040 Get size=2 addr 0x010, mem word 0xDEADBEEF, d_ready_i=1 -> mem_req_o at N+1, d_valid_o at N+3, AccessAckData, data 0xDEADBEEF, d_error_o=0.
REQ-041 PutPartial size=0 addr 0x013 mask 4'b1000 data 0xAA000000 -> mem_be_o=4'b1000, mem_addr_o=0x004, AccessAck at N+2.
REQ-042 Get size=2 addr 0x002 -> no mem_req_o, d_valid_o at N+1, d_error_o=1, d_opcode_o=1.
REQ-043 PutFull size=2 mask 4'b0111 -> rejected, d_error_o=1, d_opcode_o=0, no memory write.
REQ-044 Response with d_ready_i low 5 cycles -> d_* stable, a_ready_o=0 throughout; back-to-back request accepted the cycle after d handshake.
REQ-045 Reset asserted in WAIT_RD -> d_valid_o never asserts for that Get; IDLE, a_ready_o=1 after release.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TL-UL encodings and FSM state type for the responder.
package tl_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL    = 3'd0,
    A_PUT_PARTIAL = 3'd1,
    A_GET         = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  typedef enum logic [1:0] {
    SZ_1B   = 2'd0,
    SZ_2B   = 2'd1,
    SZ_4B   = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT_RD,
    ST_RESP
  } state_e;

  // Byte lanes covered by an access of the given size at the given word offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_1B:   lane_mask = 4'b0001 << off;
      SZ_2B:   lane_mask = 4'b0011 << {off[1], 1'b0};
      SZ_4B:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/tl_req_check.sv
// Combinational legality check of an A-channel request.
module tl_req_check
  import tl_pkg::*;
(
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_size,
  input  logic [1:0] i_addr_lo,
  input  logic [3:0] i_mask,
  output logic       o_legal
);

  logic       w_op_ok;
  logic       w_size_ok;
  logic       w_align_ok;
  logic       w_mask_ok;
  logic       w_full_ok;
  logic [3:0] w_lanes;

  always_comb begin
    w_op_ok   = (i_opcode == A_PUT_FULL) || (i_opcode == A_PUT_PARTIAL) ||
                (i_opcode == A_GET);
    w_size_ok = (i_size != SZ_RSVD);
    case (i_size)
      SZ_2B:   w_align_ok = ~i_addr_lo[0];
      SZ_4B:   w_align_ok = (i_addr_lo == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    w_lanes   = lane_mask(i_size, i_addr_lo);
    w_mask_ok = (i_mask != 4'b0000) && ((i_mask & ~w_lanes) == 4'b0000);
    // A full put must write every addressed byte, not just a subset.
    w_full_ok = (i_opcode != A_PUT_FULL) || (i_mask == w_lanes);
    o_legal   = w_op_ok && w_size_ok && w_align_ok && w_mask_ok && w_full_ok;
  end

endmodule

// File: rtl/tl_ul_responder.sv
// Single-outstanding TL-UL slave: accepts a request, issues one memory strobe,
// and returns a registered D-channel response (error response if illegal).
module tl_ul_responder
  import tl_pkg::*;
#(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  logic [2:0]    a_opcode_i,
  input  logic [1:0]    a_size_i,
  input  logic [AW-1:0] a_address_i,
  input  logic [3:0]    a_mask_i,
  input  logic [DW-1:0] a_data_i,

  output logic          d_valid_o,
  input  logic          d_ready_i,
  output logic [2:0]    d_opcode_o,
  output logic [1:0]    d_size_o,
  output logic [DW-1:0] d_data_o,
  output logic          d_error_o,

  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-3:0] mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  state_e        r_state;
  logic [2:0]    r_opcode;
  logic [1:0]    r_size;
  logic [AW-3:0] r_addr_word;
  logic [3:0]    r_mask;
  logic [DW-1:0] r_wdata;
  logic          r_mem_req;
  logic          r_mem_we;
  logic          r_d_valid;
  logic          r_d_error;
  logic [2:0]    r_d_opcode;
  logic [DW-1:0] r_d_data;
  logic          w_legal;

  tl_req_check u_req_check (
    .i_opcode  (a_opcode_i),
    .i_size    (a_size_i),
    .i_addr_lo (a_address_i[1:0]),
    .i_mask    (a_mask_i),
    .o_legal   (w_legal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_opcode    <= '0;
      r_size      <= '0;
      r_addr_word <= '0;
      r_mask      <= '0;
      r_wdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_d_valid   <= 1'b0;
      r_d_error   <= 1'b0;
      r_d_opcode  <= '0;
      r_d_data    <= '0;
    end else begin
      r_mem_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (a_valid_i) begin
            r_opcode    <= a_opcode_i;
            r_size      <= a_size_i;
            r_addr_word <= a_address_i[AW-1:2];
            r_mask      <= a_mask_i;
            r_wdata     <= a_data_i;
            if (w_legal) begin
              r_mem_req <= 1'b1;
              r_mem_we  <= (a_opcode_i != A_GET);
              r_state   <= ST_ACCESS;
            end else begin
              // Rejected requests skip memory; opcode class still picks the ack type.
              r_d_valid  <= 1'b1;
              r_d_error  <= 1'b1;
              r_d_opcode <= (a_opcode_i == A_GET) ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
              r_d_data   <= '0;
              r_state    <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          if (r_opcode == A_GET) begin
            r_state <= ST_WAIT_RD;
          end else begin
            r_d_valid  <= 1'b1;
            r_d_error  <= 1'b0;
            r_d_opcode <= D_ACCESS_ACK;
            r_d_data   <= '0;
            r_state    <= ST_RESP;
          end
        end
        ST_WAIT_RD: begin
          r_d_valid  <= 1'b1;
          r_d_error  <= 1'b0;
          r_d_opcode <= D_ACCESS_ACK_DATA;
          r_d_data   <= mem_rdata_i;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (r_d_valid && d_ready_i) begin
            r_d_valid <= 1'b0;
            r_d_error <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gated by reset so the port reads 0 while reset is held and 1 right after release.
  assign a_ready_o   = (r_state == ST_IDLE) && !reset;

  assign d_valid_o   = r_d_valid;
  assign d_opcode_o  = r_d_opcode;
  assign d_size_o    = r_size;
  assign d_data_o    = r_d_data;
  assign d_error_o   = r_d_error;

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_addr_word;
  assign mem_be_o    = r_mask;
  assign mem_wdata_o = r_wdata;

endmodule
